adder_share_arb: RTL and testbench

- Shares one 32-bit parallel-prefix adder between NREQ requesters, e.g. the FIR tap accumulators.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Accepts at most one add per cycle into a fixed-latency pipeline and returns sum, carry-out and requester ID on a single response port with backpressure.

---
 rtl/adder_share_arb_pkg.sv | 23 ++
 rtl/adder_share_arb_prefix_adder.sv | 41 ++++
 rtl/adder_share_arb.sv | 124 ++++++++++++
 tb/tb_adder_share_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arb_pkg.sv
// Shared definitions for adder_share_arb: default widths, the kpg encoding used
// by the prefix network, and the signed saturation limits for ADDER_SHARE_SAT_EN.
package adder_share_pkg;

  localparam int W_DEF    = 32;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    KILL = 2'b00,
    PROP = 2'b01,
    GEN  = 2'b10
  } kpg_e;

  localparam logic [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

  // A propagating upper group takes the status of the lower group beneath it.
  function automatic kpg_e kpg_combine(input kpg_e hi, input kpg_e lo);
    return (hi == PROP) ? lo : hi;
  endfunction

endpackage

// File: rtl/adder_share_arb_prefix_adder.sv
// Purely combinational W-bit Kogge-Stone adder built from kpg cells.
// Level l merges each bit's group with the group 2**(l-1) bits below it.
module prefix_adder
  import adder_share_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LEVELS = $clog2(W);

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    kpg_e node [W];
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (l == 0) begin : g_leaf
        assign node[i] = kpg_e'({a[i] & b[i], a[i] ^ b[i]});
      end else if (i >= (1 << (l - 1))) begin : g_cell
        assign node[i] = kpg_combine(g_lvl[l-1].node[i], g_lvl[l-1].node[i - (1 << (l - 1))]);
      end else begin : g_pass
        assign node[i] = g_lvl[l-1].node[i];
      end
    end
  end

  // After the last level node[i] covers bits [i:0]; cin resolves a full propagate.
  logic [W:0] carry;
  assign carry[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_carry
    assign carry[i+1] = (g_lvl[LEVELS].node[i] == GEN) ||
                        ((g_lvl[LEVELS].node[i] == PROP) && cin);
  end

  assign sum  = a ^ b ^ carry[W-1:0];
  assign cout = carry[W];

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin shared adder: NREQ requesters feed one LAT-stage pipeline ending in
// a prefix adder. Define ADDER_SHARE_SAT_EN for a signed saturating rsp_sum.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int LAT  = 2,
  parameter int IDW  = IDW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  logic [LAT-1:0] valid_q;
  logic [IDW-1:0] id_q [LAT];
  logic [W-1:0]   a_q  [LAT];
  logic [W-1:0]   b_q  [LAT];
  logic [LAT-1:0] cin_q;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           run_q;

  logic           advance, found, xfer;
  logic [IDW-1:0] grant;
  logic [W-1:0]   a_d, b_d;
  logic           cin_d;
  logic [W-1:0]   raw_sum;

  assign advance = !valid_q[LAT-1] || rsp_ready;

  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        grant = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // run_q keeps req_ready low while reset is held and for the first edge after.
  assign xfer = run_q && advance && found;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = xfer && (grant == IDW'(k));
    end
    a_d   = xfer ? req_a[int'(grant)*W +: W] : '0;
    b_d   = xfer ? req_b[int'(grant)*W +: W] : '0;
    cin_d = xfer && req_cin[grant];
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cin_q   <= '0;
      ptr_q   <= '0;
      run_q   <= 1'b0;
      for (int s = 0; s < LAT; s++) begin
        id_q[s] <= '0;
        a_q[s]  <= '0;
        b_q[s]  <= '0;
      end
    end else begin
      run_q <= 1'b1;
      ptr_q <= ptr_d;
      if (advance) begin
        valid_q[0] <= xfer;
        id_q[0]    <= xfer ? grant : '0;
        a_q[0]     <= a_d;
        b_q[0]     <= b_d;
        cin_q[0]   <= cin_d;
        for (int s = 1; s < LAT; s++) begin
          valid_q[s] <= valid_q[s-1];
          id_q[s]    <= id_q[s-1];
          a_q[s]     <= a_q[s-1];
          b_q[s]     <= b_q[s-1];
          cin_q[s]   <= cin_q[s-1];
        end
      end
    end
  end

  prefix_adder #(.W(W)) u_adder (
    .a    (a_q[LAT-1]),
    .b    (b_q[LAT-1]),
    .cin  (cin_q[LAT-1]),
    .sum  (raw_sum),
    .cout (rsp_cout)
  );

`ifdef ADDER_SHARE_SAT_EN
  localparam logic [W-1:0] SAT_MAX_W = W'(SAT_MAX >> (W_DEF - W));
  localparam logic [W-1:0] SAT_MIN_W = W'(SAT_MIN >> (W_DEF - W));
  logic ovf;
  // Same-sign operands producing an opposite-sign result is a signed overflow.
  assign ovf     = (a_q[LAT-1][W-1] == b_q[LAT-1][W-1]) && (raw_sum[W-1] != a_q[LAT-1][W-1]);
  assign rsp_sum = !ovf ? raw_sum : (a_q[LAT-1][W-1] ? SAT_MIN_W : SAT_MAX_W);
`else
  assign rsp_sum = raw_sum;
`endif

  assign rsp_valid = valid_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb: accepted requests are modelled and queued,
// responses are popped and compared; scenario tasks add targeted inline checks.
module tb_adder_share_arb;
  import adder_share_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_cin = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;

  int   checks = 0;
  int   errors = 0;
  int   cycleCnt = 0;
  exp_t sbQ[$];
  exp_t monExp;
  int   rspIds[$];
  int   rspCyc[$];

  adder_share_arb #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycleCnt++;
  end

  function automatic exp_t model(input logic [IDW-1:0] id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] raw;
    longint s;
    raw    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.id   = id;
    e.cout = raw[W];
    e.sum  = raw[W-1:0];
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
`ifdef ADDER_SHARE_SAT_EN
    if (s > 64'sd2147483647) e.sum = 32'h7FFF_FFFF;
    else if (s < -64'sd2147483648) e.sum = 32'h8000_0000;
`endif
    return e;
  endfunction

  // Monitor: pop and compare handshaken responses, then queue newly accepted requests.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_rsp: got id=%0d sum=%h cout=%0b, required no response",
                   rsp_id, rsp_sum, rsp_cout);
        end else begin
          monExp = sbQ.pop_front();
          if ({rsp_id, rsp_sum, rsp_cout} !== monExp) begin
            errors++;
            $display("[TB] FAIL scoreboard: got id=%0d sum=%h cout=%0b, required id=%0d sum=%h cout=%0b",
                     rsp_id, rsp_sum, rsp_cout, monExp.id, monExp.sum, monExp.cout);
          end
        end
        rspIds.push_back(int'(rsp_id));
        rspCyc.push_back(cycleCnt);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i])
          sbQ.push_back(model(IDW'(i), req_a[i*W +: W], req_b[i*W +: W], req_cin[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = $urandom();
      req_b[i*W +: W] = $urandom();
      req_cin[i]      = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sendOne(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, output bit granted);
    @(posedge clk); #1;
    req_valid[id]     = 1'b1;
    req_a[id*W +: W]  = a;
    req_b[id*W +: W]  = b;
    req_cin[id]       = c;
    granted = 1'b0;
    for (int n = 0; n < 20 && !granted; n++) begin
      @(negedge clk);
      if (req_ready[id]) granted = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drainWait(output bit timedOut);
    timedOut = 1'b1;
    for (int n = 0; n < 40 && timedOut; n++) begin
      @(negedge clk);
      if (!busy) timedOut = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    sbQ.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    applyStimulus();
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0b, required 0", rsp_valid); end
    checks++; if (rsp_id !== '0) begin errors++; $display("[TB] FAIL reset_rsp_id: got %0d, required 0", rsp_id); end
    checks++; if (rsp_sum !== '0) begin errors++; $display("[TB] FAIL reset_rsp_sum: got %h, required 0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_cout: got %0b, required 0", rsp_cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy); end
    checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b, required 0", req_ready); end
    req_valid = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    bit granted, to;
    logic expEarly;
    expEarly  = (LAT == 1);
    rsp_ready = 1'b1;
    sendOne(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, granted);
    checks++; if (!granted) begin errors++; $display("[TB] FAIL single_grant: got no grant, required grant"); end
    checks++; if (rsp_valid !== expEarly) begin errors++; $display("[TB] FAIL single_latency: got rsp_valid=%0b, required %0b", rsp_valid, expEarly); end
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b, required 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id: got %0d, required 0", rsp_id); end
    checks++; if (rsp_sum !== 32'h0000_0100) begin errors++; $display("[TB] FAIL single_sum: got %h, required 00000100", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("[TB] FAIL single_cout: got %0b, required 0", rsp_cout); end
    drainWait(to);
    checks++; if (to || sbQ.size() != 0) begin errors++; $display("[TB] FAIL single_drain: got timeout=%0b pending=%0d, required 0 0", to, sbQ.size()); end
  endtask

  task automatic test_carry();
    bit granted, to;
    sendOne(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, granted);
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++; if (!granted || {rsp_valid, rsp_sum, rsp_cout} !== {1'b1, 32'h0, 1'b1}) begin
      errors++; $display("[TB] FAIL carry_ones: got valid=%0b sum=%h cout=%0b, required 1 00000000 1", rsp_valid, rsp_sum, rsp_cout); end
    sendOne(2, 32'h8000_0000, 32'h8000_0000, 1'b0, granted);
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++; if (!granted || {rsp_valid, rsp_sum, rsp_cout} !== {1'b1, 32'h0, 1'b1}) begin
      errors++; $display("[TB] FAIL carry_msb: got valid=%0b sum=%h cout=%0b, required 1 00000000 1", rsp_valid, rsp_sum, rsp_cout); end
    drainWait(to);
    checks++; if (to || sbQ.size() != 0) begin errors++; $display("[TB] FAIL carry_drain: got timeout=%0b pending=%0d, required 0 0", to, sbQ.size()); end
  endtask

  task automatic test_round_robin();
    bit to, gotFirst;
    logic [NREQ-1:0] expGrant;
    doReset();
    rspIds.delete();
    rspCyc.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '1;
    applyStimulus();
    gotFirst = 1'b0;
    for (int n = 0; n < 10 && !gotFirst; n++) begin
      @(negedge clk);
      if (req_ready != '0) gotFirst = 1'b1;
    end
    checks++; if (!gotFirst) begin errors++; $display("[TB] FAIL rr_first_grant: got none, required grant"); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      expGrant = NREQ'(1 << (k % NREQ));
      checks++; if (req_ready !== expGrant) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %b, required %b", k, req_ready, expGrant); end
      @(posedge clk); #1;
      if (k == 7) req_valid = '0;
      else applyStimulus();
    end
    drainWait(to);
    checks++; if (to || sbQ.size() != 0 || rspIds.size() != 8) begin
      errors++; $display("[TB] FAIL rr_count: got timeout=%0b pending=%0d responses=%0d, required 0 0 8", to, sbQ.size(), rspIds.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (rspIds[k] != k % NREQ) begin errors++; $display("[TB] FAIL rr_rsp_id_%0d: got %0d, required %0d", k, rspIds[k], k % NREQ); end
      end
      checks++; if (rspCyc[7] - rspCyc[0] != 7) begin errors++; $display("[TB] FAIL rr_throughput: got span %0d cycles, required 7", rspCyc[7] - rspCyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [IDW-1:0] hid;
    logic [W-1:0]   hsum;
    logic           hcout;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '1;
    applyStimulus();
    repeat (3) begin
      @(posedge clk); #1;
      applyStimulus();
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %0b, required 1", rsp_valid); end
    hid = rsp_id; hsum = rsp_sum; hcout = rsp_cout;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL bp_ready_%0d: got %b, required 0000", c, req_ready); end
      checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, hid, hsum, hcout}) begin
        errors++; $display("[TB] FAIL bp_hold_%0d: got id=%0d sum=%h cout=%0b, required id=%0d sum=%h cout=%0b",
                           c, rsp_id, rsp_sum, rsp_cout, hid, hsum, hcout); end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      applyStimulus();
    end
    req_valid = '0;
    drainWait(to);
    checks++; if (to || sbQ.size() != 0) begin errors++; $display("[TB] FAIL bp_drain: got timeout=%0b pending=%0d, required 0 0", to, sbQ.size()); end
  endtask

  task automatic test_reset_mid();
    bit to, sawRsp, gotGrant;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    checks++; if ({busy, rsp_valid} !== 2'b11) begin errors++; $display("[TB] FAIL mid_inflight: got busy=%0b valid=%0b, required 1 1", busy, rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, busy, rsp_cout} !== 3'b000) begin errors++; $display("[TB] FAIL mid_flags: got valid=%0b busy=%0b cout=%0b, required 0 0 0", rsp_valid, busy, rsp_cout); end
    checks++; if ({rsp_id, rsp_sum} !== '0) begin errors++; $display("[TB] FAIL mid_data: got id=%0d sum=%h, required 0 0", rsp_id, rsp_sum); end
    sbQ.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    sawRsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1'b1;
    end
    checks++; if (sawRsp) begin errors++; $display("[TB] FAIL mid_no_rsp: got a response, required none"); end
    @(posedge clk); #1;
    req_valid = '1;
    applyStimulus();
    gotGrant = 1'b0;
    for (int n = 0; n < 10 && !gotGrant; n++) begin
      @(negedge clk);
      if (req_ready != '0) gotGrant = 1'b1;
    end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_next_grant: got %b, required 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    drainWait(to);
    checks++; if (to || sbQ.size() != 0) begin errors++; $display("[TB] FAIL mid_drain: got timeout=%0b pending=%0d, required 0 0", to, sbQ.size()); end
  endtask

  task automatic test_sat();
    bit granted, to;
    logic [W-1:0] expPos, expNeg;
`ifdef ADDER_SHARE_SAT_EN
    expPos = 32'h7FFF_FFFF;
    expNeg = 32'h8000_0000;
`else
    expPos = 32'h8000_0000;
    expNeg = 32'h7FFF_FFFF;
`endif
    sendOne(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, granted);
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++; if (!granted || {rsp_valid, rsp_sum, rsp_cout} !== {1'b1, expPos, 1'b0}) begin
      errors++; $display("[TB] FAIL sat_pos: got valid=%0b sum=%h cout=%0b, required 1 %h 0", rsp_valid, rsp_sum, rsp_cout, expPos); end
    sendOne(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, granted);
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++; if (!granted || {rsp_valid, rsp_sum, rsp_cout} !== {1'b1, expNeg, 1'b1}) begin
      errors++; $display("[TB] FAIL sat_neg: got valid=%0b sum=%h cout=%0b, required 1 %h 1", rsp_valid, rsp_sum, rsp_cout, expNeg); end
    drainWait(to);
    checks++; if (to || sbQ.size() != 0) begin errors++; $display("[TB] FAIL sat_drain: got timeout=%0b pending=%0d, required 0 0", to, sbQ.size()); end
  endtask

  initial begin
    $display("[TB] starting adder_share_arb bench");
    test_reset();
    test_single_op();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
